// File: rtl/shifter_pkg.sv
// shifter_pkg: shared mode/state types and status bit positions for the sequential shift unit
package shifter_pkg;
  typedef enum logic [1:0] {LSR = 2'b00, ASR = 2'b01, LSL = 2'b10, ROR = 2'b11} shift_mode_t;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} shift_state_t;
  localparam int ST_INVALID = 3;
  localparam int ST_RANGE = 2;
  localparam int ST_ZERO = 1;
  localparam int ST_CARRY = 0;
  function automatic logic [3:0] status_word(input logic invalid, input logic rng, input logic zero, input logic carry);
    logic [3:0] s;
    s = '0;
    s[ST_INVALID] = invalid;
    s[ST_RANGE] = rng;
    s[ST_ZERO] = zero;
    s[ST_CARRY] = carry;
    return s;
  endfunction
endpackage

// File: rtl/seq_shift_unit_if.sv
// seq_shift_unit_if: start/busy/done handshake plus operand and result bus of the shift unit
interface seq_shift_unit_if #(parameter int M = 8);
  logic i_start;
  logic [1:0] i_mode;
  logic [M-1:0] i_arg_A;
  logic [M-1:0] i_arg_B;
  logic o_busy;
  logic o_done;
  logic [M-1:0] o_result;
  logic [3:0] o_status;
  modport master (output i_start, i_mode, i_arg_A, i_arg_B, input o_busy, o_done, o_result, o_status);
  modport slave (input i_start, i_mode, i_arg_A, i_arg_B, output o_busy, o_done, o_result, o_status);
endinterface

// File: rtl/shift_step.sv
// shift_step: one 1-bit shift/rotate step of the work register and the bit that leaves it
module shift_step import shifter_pkg::*; #(parameter int M = 8) (
  input  logic [M-1:0] i_work,
  input  shift_mode_t  i_mode,
  output logic [M-1:0] o_next,
  output logic         o_out
);
  // left for LSL; otherwise right with zero, sign or wrapped-bit fill
  always_comb begin
    o_next = (i_mode == LSL) ? {i_work[M-2:0], 1'b0}
           : {(i_mode == ASR) ? i_work[M-1] : (i_mode == ROR) ? i_work[0] : 1'b0, i_work[M-1:1]};
    o_out = (i_mode == LSL) ? i_work[M-1] : i_work[0];
  end
endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle LSR/ASR/LSL/ROR unit shifting one bit per clock behind start/busy/done
module seq_shift_unit import shifter_pkg::*; #(
  parameter int M = 8,
  parameter int SW = $clog2(M) + 1
) (
  input logic i_clk,
  input logic i_rst,
  seq_shift_unit_if.slave bus
);
  localparam logic [M-1:0] LP_M = M[M-1:0];
  shift_state_t r_state, w_next;
  shift_mode_t r_mode;
  logic [M-1:0] r_work, r_result, w_step, w_n;
  logic [SW-1:0] r_count, w_load;
  logic [3:0] r_status;
  logic r_carry, r_range, r_invalid, w_out, w_accept, w_invalid;

  shift_step #(.M(M)) u_step (.i_work(r_work), .i_mode(r_mode), .o_next(w_step), .o_out(w_out));

  // decode the one's-complement amount: capped count for shifts, modulo-M count for rotate
  always_comb begin
    w_n = ~bus.i_arg_B;
    w_invalid = ~bus.i_arg_B[M-1];
    w_accept = (r_state == IDLE) && bus.i_start;
    w_load = w_invalid ? '0
           : (shift_mode_t'(bus.i_mode) == ROR) ? {1'b0, w_n[SW-2:0]}
           : (w_n >= LP_M) ? SW'(M) : w_n[SW-1:0];
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next state: SHIFT until the count is exhausted, DONE lasts exactly one cycle
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (bus.i_start ? SHIFT : IDLE)
           : (r_state == SHIFT) ? ((r_count == '0) ? DONE : SHIFT)
           : IDLE;
    bus.o_busy = (r_state != IDLE);
    bus.o_done = (r_state == DONE);
  end

  // operand latch on start, one step per cycle, result/status capture when the count runs out
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= LSR;
      r_work <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_range <= 1'b0;
      r_invalid <= 1'b0;
      r_result <= '0;
      r_status <= '0;
    end else if (w_accept) begin
      r_mode <= shift_mode_t'(bus.i_mode);
      r_work <= w_invalid ? '0 : bus.i_arg_A;
      r_count <= w_load;
      r_carry <= 1'b0;
      r_range <= (w_n >= LP_M);
      r_invalid <= w_invalid;
    end else if (r_state == SHIFT && r_count != '0) begin
      r_work <= w_step;
      r_carry <= w_out;
      r_count <= r_count - SW'(1);
    end else if (r_state == SHIFT) begin
      r_result <= r_invalid ? '0 : r_work;
      r_status <= r_invalid ? status_word(1'b1, 1'b0, 1'b0, 1'b0)
                            : status_word(1'b0, r_range, r_work == '0, r_carry);
    end
  end

  assign bus.o_result = r_result;
  assign bus.o_status = r_status;
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: scoreboard bench for seq_shift_unit against an arithmetic reference model
module tb_seq_shift_unit;
  import shifter_pkg::*;
  localparam int M = 8;
  typedef struct {
    logic [M-1:0] res;
    logic [3:0]   st;
    int           lat;
    int           e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t q[$];

  seq_shift_unit_if #(.M(M)) bus();
  seq_shift_unit #(.M(M)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b, input logic [1:0] md);
    exp_t e;
    logic [M-1:0] n;
    logic [2*M-1:0] aa;
    int cnt;
    logic c;
    n = ~b;
    e.e0 = 0;
    if (!b[M-1]) begin
      e.res = '0;
      e.st = 4'b1000;
      e.lat = 1;
      return e;
    end
    cnt = (md == 2'b11) ? int'(n) % M : ((int'(n) >= M) ? M : int'(n));
    c = 1'b0;
    case (md)
      2'b00: begin e.res = a >> cnt; if (cnt > 0) c = a[cnt-1]; end
      2'b01: begin e.res = M'($signed(a) >>> cnt); if (cnt > 0) c = a[cnt-1]; end
      2'b10: begin e.res = a << cnt; if (cnt > 0) c = a[M-cnt]; end
      default: begin aa = {a, a} >> cnt; e.res = aa[M-1:0]; if (cnt > 0) c = a[cnt-1]; end
    endcase
    e.st = {1'b0, int'(n) >= M, e.res == '0, c};
    e.lat = cnt + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.o_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: o_done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("result", bus.o_result, e.res);
        check("status", bus.o_status, e.st);
        check("latency", cyc - e.e0, e.lat);
        check("busy_in_done", bus.o_busy, 1);
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", q.size(), 0);
    if (q.size() != 0) q.delete();
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.o_busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("idle_before_start", bus.o_busy, 0);
  endtask

  task automatic issue(input logic [M-1:0] a, input logic [M-1:0] b, input logic [1:0] md, input bit track);
    exp_t e;
    wait_idle();
    bus.i_arg_A = a;
    bus.i_arg_B = b;
    bus.i_mode = md;
    bus.i_start = 1'b1;
    if (track) begin
      e = model(a, b, md);
      e.e0 = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_arg_A = M'($urandom);
    bus.i_arg_B = M'($urandom);
    bus.i_mode = 2'($urandom);
  endtask

  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [1:0] md);
    issue(a, b, md, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [M-1:0] a, b;
    bus.i_start = 1'b0;
    bus.i_mode = 2'b00;
    bus.i_arg_A = '0;
    bus.i_arg_B = '1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_result", bus.o_result, 0);
    check("rst_status", bus.o_status, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'hB4, 8'hFC, LSR);
    run_op(8'h90, 8'hFE, ASR);
    run_op(8'h81, 8'hF0, LSL);
    run_op(8'h01, 8'hFE, ROR);
    run_op(8'h01, 8'hFF, ROR);
    run_op(8'hA5, 8'h7F, ASR);
    run_op(8'h5A, 8'h7F, ROR);
    issue(8'h03, 8'hF9, LSL, 1'b1);
    @(negedge clk);
    bus.i_arg_A = 8'hFF;
    bus.i_arg_B = 8'hFE;
    bus.i_mode = ROR;
    bus.i_start = 1'b1;
    check("busy_during_shift", bus.o_busy, 1);
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();
    issue(8'h03, 8'hF9, LSL, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_busy", bus.o_busy, 0);
    check("midop_rst_done", bus.o_done, 0);
    check("midop_rst_result", bus.o_result, 0);
    check("midop_rst_status", bus.o_status, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("idle_after_rst", bus.o_busy, 0);
    run_op(8'h03, 8'hF9, LSL);
    repeat (40) begin
      a = M'($urandom);
      b = ($urandom_range(0, 3) == 0) ? M'($urandom) : ~M'($urandom_range(0, 12));
      run_op(a, b, 2'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Parametrised, multi-cycle shift unit for the ALU submodule set. It supersedes the single-mode combinational right shifter. It supports logical right, arithmetic right, logical left and rotate-right modes at width `M`. The shift amount keeps the one's-complement `~i_arg_B` encoding, and the unit shifts one bit position per clock behind a start/busy/done handshake. It drives `o_result`/`o_status` into the ALU output mux like the other submodules.

## Interface
- `M`, default 8: operand and result width; must be a power of two, ≥ 4.
- `SW`, default `$clog2(M)+1`: internal shift-counter width; derived, not to be overridden.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_start` input 1: start request; sampled only in IDLE.
- `i_mode` input 2: operation select. 00 = LSR, 01 = ASR, 10 = LSL, 11 = ROR.
- `i_arg_A` input M: operand to shift.
- `i_arg_B` input M: encoded shift amount; N = `~i_arg_B` (unsigned).
- `o_busy` output 1: high in SHIFT and DONE.
- `o_done` output 1: single-cycle completion pulse.
- `o_result` output M: registered result; held until the next accepted start.
- `o_status` output 4: registered flags.
  - [3] invalid encoding
  - [2] amount ≥ M
  - [1] result zero
  - [0] carry (last bit shifted or rotated out)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE transitions:
  - `i_start`=1 → SHIFT.
  - On the same edge, latch A into the work register and latch the mode.
  - Clear carry and load the counter (see below).
- Invalid encoding: if `i_arg_B[M-1]`==0 at start, the count is 0, the work register is 0 and a flag is latched so the final status is exactly 4'b1000.
- Count loading:
  - LSR/ASR/LSL: count = min(N, M).
  - ROR: count = N mod M.
  - Flag [2] is latched if N ≥ M, in every mode.
- SHIFT, count ≠ 0: perform one 1-bit step, set carry to the bit leaving the register, decrement the count.
  - LSR: shift right, fill with 0, carry = bit 0.
  - ASR: shift right, fill with the current MSB, carry = bit 0.
  - LSL: shift left, fill with 0, carry = bit M-1.
  - ROR: rotate right, carry = bit 0 (the bit wrapped to the MSB).
- SHIFT, count == 0: → DONE. On this edge write `o_result` from the work register and write `o_status`.
  - [1] = (result == 0).
  - [0] = carry.
  - [2] as latched.
  - Invalid case: status overrides to 4'b1000 and result is 0.
- DONE: `o_done`=1 for exactly one cycle, then → IDLE unconditionally.
- `i_start` while `o_busy`=1 is ignored. No queuing; latched operands are unaffected.
- Input changes after the start edge have no effect on the running operation.

## Timing
- Reset values: state IDLE; `o_busy`=0, `o_done`=0, `o_result`=0, `o_status`=4'b0000; internal registers 0.
- Let the start edge be E0 and C the loaded count. `o_result` and `o_status` update at edge E(C+1), and `o_done` is high during the cycle after E(C+1).
  - Latency is C+1 cycles; the invalid case takes 1 cycle.
- Back-to-back operation: next start is accepted no earlier than the cycle after `o_done`. Minimum issue interval is C+3 cycles.
- Reset asserted mid-SHIFT or mid-DONE:
  - All outputs are forced immediately to their reset values.
  - The operation is discarded and no `o_done` is produced.
- Maximum latency is M+1 cycles (capped count).

## Structure
- Package `shifter_pkg` contains:
  - typedef enum `shift_mode_t` (LSR, ASR, LSL, ROR);
  - typedef enum `shift_state_t` (IDLE, SHIFT, DONE);
  - status bit index constants `ST_INVALID`=3, `ST_RANGE`=2, `ST_ZERO`=1, `ST_CARRY`=0.
- Sub-module `shift_step` is combinational and parametrised by `M`: inputs are work register and mode; outputs are next register value and out-bit.
- Top level holds the FSM, counter, work register and output registers.

## Test plan
- LSR: A=8'hB4, B=8'hFC (N=3) → `o_done` 4 cycles after start; result 8'h16, status 4'b0001.
- ASR: A=8'h90, B=8'hFE (N=1) → latency 2; result 8'hC8, status 4'b0000.
- LSL: A=8'h81, B=8'hF0 (N=15) → count capped at 8, latency 9; result 8'h00, status 4'b0111.
- ROR: A=8'h01, B=8'hFE → result 8'h80, status 4'b0001.
  - Then ROR with B=8'hFF (N=0) → latency 1, result 8'h01, status 4'b0000.
- Invalid encoding: B=8'h7F, any mode → latency 1; result 8'h00, status 4'b1000.
- Mid-operation behaviour, LSL with N=6:
  - A second `i_start` with different operands during SHIFT is ignored; the result matches the first operation.
  - A rerun with `i_rst` pulsed at cycle 3 → all outputs 0 immediately, no `o_done`, FSM back in IDLE.
